// File: rtl/alu_pkg.sv
// Shared op codes, widths and request/response records for the add/mul dispatcher.
// Results are RES_W wide; adder sums are zero-extended into that width.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int OPND_W = 4;
  localparam int TAG_W  = 4;
  localparam int SUM_W  = OPND_W + 1;
  localparam int RES_W  = 2 * OPND_W;

  typedef struct packed {
    logic              op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic             op;
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] data;
  } rsp_t;

  function automatic logic [RES_W-1:0] pick_result(input logic op,
                                                   input logic [SUM_W-1:0] sum,
                                                   input logic [RES_W-1:0] prod);
    return (op == OP_MUL) ? prod : {{(RES_W-SUM_W){1'b0}}, sum};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered full/empty, head visible combinationally on pop_dat.
// Push ignored when full, pop ignored when empty; simultaneous push and pop are allowed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Index wraps at DEPTH (not 2**AW) and flips the lap bit, so any depth works.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + ptr_t'(1);
  endfunction

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Queues add/mul requests, issues them credit-gated to an external registered adder/multiplier, returns in order.
// Accept at edge K -> rsp_valid after K+3; req_ready falls only on a full request FIFO, stalled responses hold.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [OPND_W-1:0] req_a,
  input  logic [OPND_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [OPND_W-1:0] aa,
  output logic [OPND_W-1:0] ab,
  output logic [OPND_W-1:0] ma,
  output logic [OPND_W-1:0] mb,
  input  logic [SUM_W-1:0]  aout,
  input  logic [RES_W-1:0]  mout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_op,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [RES_W-1:0]  rsp_data
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  req_t              req_in, req_head;
  rsp_t              rsp_in, rsp_head;
  logic              req_full, req_empty;
  logic              rsp_full, rsp_empty;
  logic              issue, rsp_push, rsp_pop;

  logic              live_q, live_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [OPND_W-1:0] aa_q, aa_d, ab_q, ab_d;
  logic [OPND_W-1:0] ma_q, ma_d, mb_q, mb_d;
  logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic              s1_op_q, s1_op_d, s2_op_q, s2_op_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;

  assign req_in    = '{op: req_op, a: req_a, b: req_b, tag: req_tag};
  assign req_ready = live_q && !req_full;

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (req_valid && req_ready),
    .push_dat (req_in),
    .full     (req_full),
    .pop_rdy  (issue),
    .pop_dat  (req_head),
    .empty    (req_empty)
  );

  // A credit covers an op from issue until its response leaves the buffer.
  assign issue    = !req_empty && (credits_q != '0);
  assign rsp_push = s2_vld_q;
  assign rsp_pop  = !rsp_empty && rsp_ready;
  assign rsp_in   = '{op: s2_op_q, tag: s2_tag_q, data: pick_result(s2_op_q, aout, mout)};

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (rsp_push),
    .push_dat (rsp_in),
    .full     (rsp_full),
    .pop_rdy  (rsp_pop),
    .pop_dat  (rsp_head),
    .empty    (rsp_empty)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_push && rsp_full));

  always_comb begin
    live_d    = 1'b1;
    credits_d = credits_q - CW'(issue) + CW'(rsp_pop);
    aa_d      = aa_q;
    ab_d      = ab_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    s1_vld_d  = issue;
    s1_op_d   = req_head.op;
    s1_tag_d  = req_head.tag;
    s2_vld_d  = s1_vld_q;
    s2_op_d   = s1_op_q;
    s2_tag_d  = s1_tag_q;
    if (issue) begin
      if (req_head.op == OP_MUL) begin
        ma_d = req_head.a;
        mb_d = req_head.b;
      end else begin
        aa_d = req_head.a;
        ab_d = req_head.b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      credits_q <= CW'(RSP_DEPTH);
      aa_q      <= '0;
      ab_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_op_q   <= 1'b0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_op_q   <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      live_q    <= live_d;
      credits_q <= credits_d;
      aa_q      <= aa_d;
      ab_q      <= ab_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      s1_vld_q  <= s1_vld_d;
      s1_op_q   <= s1_op_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_op_q   <= s2_op_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign aa        = aa_q;
  assign ab        = ab_q;
  assign ma        = ma_q;
  assign mb        = mb_q;
  assign rsp_valid = !rsp_empty;
  assign rsp_op    = rsp_valid ? rsp_head.op   : 1'b0;
  assign rsp_tag   = rsp_valid ? rsp_head.tag  : '0;
  assign rsp_data  = rsp_valid ? rsp_head.data : '0;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a queue-based reference model and an external registered adder/multiplier.
module tb_alu_dispatch;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_op;
  logic [3:0] req_a, req_b, req_tag;
  logic [3:0] aa, ab, ma, mb;
  logic [4:0] aout;
  logic [7:0] mout;
  logic       rsp_valid, rsp_ready, rsp_op;
  logic [3:0] rsp_tag;
  logic [7:0] rsp_data;

  typedef struct packed {
    logic       op;
    logic [3:0] tag;
    logic [7:0] data;
  } exp_t;

  exp_t        model_q[$];
  exp_t        e_new;
  logic [11:0] log_q[$];
  int          total = 0;
  int          bad = 0;
  int          vld_cycles = 0;
  logic        rand_rdy = 1'b0;
  logic        prev_hold = 1'b0;
  logic [13:0] prev_rsp = '0;
  logic        ext_rst;

  always #5 clk = ~clk;

  alu_dispatch #(.REQ_DEPTH(4), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .aa        (aa),
    .ab        (ab),
    .ma        (ma),
    .mb        (mb),
    .aout      (aout),
    .mout      (mout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op    (rsp_op),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data)
  );

  // Existing registered adder/multiplier; its reset is active-high.
  assign ext_rst = !rst_n;
  always_ff @(posedge clk or posedge ext_rst) begin
    if (ext_rst) begin
      aout <= '0;
      mout <= '0;
    end else begin
      aout <= 5'(aa) + 5'(ab);
      mout <= 8'(ma) * 8'(mb);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      prev_hold = 1'b0;
      chk("reset_outputs", 32'({req_ready, aa, ab, ma, mb, rsp_valid, rsp_op, rsp_tag, rsp_data}), 0);
    end else begin
      if (prev_hold) chk("rsp_hold", 32'({rsp_valid, rsp_op, rsp_tag, rsp_data}), 32'(prev_rsp));
      if (rsp_valid) begin
        vld_cycles++;
        chk("rsp_expected", 32'(model_q.size() != 0), 1);
        if (model_q.size() != 0) begin
          chk("rsp_content", 32'({rsp_op, rsp_tag, rsp_data}), 32'(model_q[0]));
          if (rsp_ready) begin
            model_q.delete(0);
            log_q.push_back({rsp_tag, rsp_data});
          end
        end
      end
      if (req_valid && req_ready) begin
        e_new.op   = req_op;
        e_new.tag  = req_tag;
        e_new.data = req_op ? 8'(req_a) * 8'(req_b) : 8'(req_a) + 8'(req_b);
        model_q.push_back(e_new);
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_valid, rsp_op, rsp_tag, rsp_data};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((model_q.size() != 0 || rsp_valid) && n < 300) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    rsp_ready = 1'b1;
    chk("drain", 32'(model_q.size()), 0);
    step(1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(req_ready), 0);
    step(1);
    chk("ready_after_edge", 32'(req_ready), 1);
  endtask

  logic [7:0]  bp_a  [6] = '{8'd3, 8'd7, 8'd12, 8'd15, 8'd0, 8'd11};
  logic [7:0]  bp_b  [6] = '{8'd5, 8'd9, 8'd4, 8'd1, 8'd11, 8'd6};
  logic [7:0]  bp_exp[6] = '{8'd8, 8'd63, 8'd16, 8'd15, 8'd11, 8'd66};
  logic [12:0] lit;
  int          base;
  int          v0;

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_reset();

    // Single add: latency and literal result.
    send(OP_ADD, 4'd9, 4'd8, 4'd3);
    @(negedge clk); chk("lat_k0", 32'(rsp_valid), 0);
    @(negedge clk); chk("lat_k1", 32'(rsp_valid), 0);
    chk("add_operands", 32'({aa, ab}), 32'h98);
    @(negedge clk); chk("lat_k2", 32'(rsp_valid), 0);
    @(negedge clk); chk("lat_k3", 32'(rsp_valid), 1);
    lit = {1'b0, 4'd3, 8'd17};
    chk("add_rsp", 32'({rsp_op, rsp_tag, rsp_data}), 32'(lit));
    drain();

    // Single mul: adder operands untouched.
    send(OP_MUL, 4'd15, 4'd15, 4'hA);
    repeat (4) @(negedge clk);
    lit = {1'b1, 4'hA, 8'hE1};
    chk("mul_rsp", 32'({rsp_valid, rsp_op, rsp_tag, rsp_data}), 32'({1'b1, lit}));
    chk("mul_operands", 32'({ma, mb}), 32'hFF);
    chk("add_ops_held", 32'({aa, ab}), 32'h98);
    drain();

    // Backpressure: two in the buffer, four queued.
    rsp_ready = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 6; i++) send(1'(i % 2), bp_a[i][3:0], bp_b[i][3:0], 4'(i));
    step(3);
    chk("bp_req_ready", 32'(req_ready), 0);
    chk("bp_head", 32'({rsp_valid, rsp_tag}), 32'h10);
    drain();
    for (int i = 0; i < 6; i++) chk("bp_result", 32'(log_q[base + i]), 32'({4'(i), bp_exp[i]}));

    // Interleaved stream with random response backpressure.
    base = log_q.size();
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send(1'(i % 2), 4'(i * 7 + 3), 4'(i * 11 + 5), 4'(i));
    rand_rdy = 1'b0;
    drain();
    chk("stream_count", 32'(log_q.size() - base), 16);
    for (int i = 0; i < 16; i++) chk("stream_tag", 32'(log_q[base + i][11:8]), 32'(i));

    // Pointer wrap with exact full/empty at each boundary.
    for (int r = 0; r < 3; r++) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        send(1'((i + r) % 2), 4'(r * 5 + i), 4'(i + 2), 4'(r * 6 + i));
        chk("wrap_ready", 32'(req_ready), (i < 5) ? 1 : 0);
      end
      drain();
      chk("wrap_empty", 32'({req_ready, rsp_valid}), 32'h2);
    end

    // Reset with queued, in-flight and buffered ops.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(1'(i % 2), 4'(i + 1), 4'd2, 4'(8 + i));
    step(3);
    chk("pre_reset_full", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({req_ready, aa, ab, ma, mb, rsp_valid, rsp_op, rsp_tag, rsp_data}), 0);
    step(2);
    release_reset();
    rsp_ready = 1'b1;
    v0 = vld_cycles;
    step(10);
    chk("no_stale", 32'(vld_cycles - v0), 0);
    send(OP_MUL, 4'd3, 4'd5, 4'h7);
    drain();
    chk("post_reset_rsp", 32'(log_q[log_q.size() - 1]), 32'h70F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
